alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter: EXEC_CYCLES, default 1, ALU settle cycles after the opcode write (legal 1..15).
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: cmd_valid  in  1  command offered.
REQ-005 SHALL have port: cmd_ready  out  1  controller accepts command.
REQ-006 SHALL have ports: cmd_a, cmd_b, cmd_op  in  4 each  operand A, operand B, opcode.
REQ-007 SHALL have ports: mem_wr_enb, mem_rd_enb  out  1 each  memory write/read enables.
REQ-008 SHALL have ports: mem_addr  out  2, mem_wr_data  out  4  memory address and write data.
REQ-009 SHALL have port: mem_rd_data  in  4  memory combinational read data.
REQ-010 SHALL have port: alu_result  in  4  ALU output computed from memory slots 1..3.
REQ-011 SHALL have ports: res_valid  out  1, res_data  out  4, res_ready  in  1  result handshake.
REQ-012 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WR_A, WR_B, WR_OP, EXEC, WB, RD, HOLD.
REQ-014 IDLE: cmd_ready=1; on cmd_valid=1, SHALL latch cmd_a/cmd_b/cmd_op and go to WR_A.
REQ-015 WR_A/WR_B/WR_OP: mem_wr_enb=1, mem_addr=1/2/3, mem_wr_data=latched A/B/op; one cycle each, in order.
REQ-016 EXEC: all memory enables 0; SHALL stay exactly EXEC_CYCLES cycles via down-counter loaded on WR_OP exit, then go to WB.
REQ-017 WB: mem_wr_enb=1, mem_addr=0, mem_wr_data=alu_result; one cycle, then go to RD.
REQ-018 RD: mem_rd_enb=1, mem_addr=0; at the clock edge, res_data<=mem_rd_data, res_valid<=1; go to HOLD.
REQ-019 HOLD: res_valid=1 and res_data stable until a cycle with res_ready=1; then res_valid<=0, go to IDLE.
REQ-020 Memory port outputs SHALL be decoded from state only (Moore); mem_addr=0 and mem_wr_data=0 when unused.
REQ-021 cmd_ready SHALL be 0 outside IDLE; cmd_valid outside IDLE SHALL be ignored, with no latching.
REQ-022 Latency: handshake edge to first res_valid=1 cycle SHALL be 6+EXEC_CYCLES cycles.
REQ-023 Back-to-back: res_ready=1 already high when res_valid rises SHALL give a 1-cycle res_valid; cmd_ready SHALL be 1 on the next cycle.
REQ-024 mem_wr_enb and mem_rd_enb SHALL never both be 1 in the same cycle.
REQ-025 All data paths SHALL be 4-bit, with no truncation or extension.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE from any state, including mid-sequence.
REQ-027 On reset, outputs SHALL be: cmd_ready=1 after release, res_valid=0, res_data=0, busy=0, mem enables 0, mem_addr=0, mem_wr_data=0.
REQ-028 On reset, latched operands and the EXEC counter SHALL clear to 0.
REQ-029 The controller SHALL NOT clear memory contents on reset.

Structure
REQ-030 Shared package alu_pkg SHALL hold the FSM state enum and address constants ADDR_RES=0, ADDR_A=1, ADDR_B=2, ADDR_OP=3.
REQ-031 The block SHALL be a single module with no sub-module; the memory and ALU SHALL be instantiated beside it by the parent.
REQ-032 EXEC counter width SHALL be 4 bits.

Verification
REQ-033 Basic: EXEC_CYCLES=1, cmd a=3, b=5, op=ADD -> writes addr1=3, addr2=5, addr3=op on successive cycles; WB writes 8 to addr0; res_data=8 with res_valid 7 cycles after the handshake.
REQ-034 Busy reject: second cmd_valid (a=1, b=1) during EXEC -> cmd_ready=0, no memory writes with a=1; first result unchanged.
REQ-035 Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid and res_data held; IDLE one cycle after res_ready=1.
REQ-036 Reset mid-op: rst=1 during WR_B -> next cycle IDLE, busy=0, res_valid=0; addr2 not written thereafter.
REQ-037 Parameter: EXEC_CYCLES=4, a=2, b=2 -> EXEC lasts exactly 4 cycles; res_valid 10 cycles after the handshake.
REQ-038 Back-to-back: res_ready tied 1, two queued commands -> second accepted the cycle after HOLD; enable-exclusivity assertion holds throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller and its parent:
// FSM state encoding, memory slot map and the opcode values the ALU decodes.
package alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_A  = 3'd1,
    S_WR_B  = 3'd2,
    S_WR_OP = 3'd3,
    S_EXEC  = 3'd4,
    S_WB    = 3'd5,
    S_RD    = 3'd6,
    S_HOLD  = 3'd7
  } state_t;

  // Memory slot map shared by controller, memory and ALU.
  localparam logic [1:0] ADDR_RES = 2'd0;
  localparam logic [1:0] ADDR_A   = 2'd1;
  localparam logic [1:0] ADDR_B   = 2'd2;
  localparam logic [1:0] ADDR_OP  = 2'd3;

  // Opcodes understood by the companion ALU; the controller passes them through.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller: writes A, B and the opcode into memory slots 1..3,
// waits EXEC_CYCLES for the ALU to settle, writes the ALU result to slot 0,
// reads it back and presents it on a valid/ready result port.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_op,
  output logic       mem_wr_enb,
  output logic       mem_rd_enb,
  output logic [1:0] mem_addr,
  output logic [3:0] mem_wr_data,
  input  logic [3:0] mem_rd_data,
  input  logic [3:0] alu_result,
  output logic       res_valid,
  output logic [3:0] res_data,
  input  logic       res_ready,
  output logic       busy
);

  // Counter load value; legal EXEC_CYCLES range 1..15 fits in 4 bits.
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

  state_t     state, state_nx;
  logic [3:0] lat_a, lat_b, lat_op;
  logic [3:0] exec_cnt;

  // State register; reset returns to IDLE from anywhere in the sequence.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Operand latches, settle counter and the registered result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_a     <= '0;
      lat_b     <= '0;
      lat_op    <= '0;
      exec_cnt  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      // Operands are captured only on the accepting IDLE cycle.
      if (state == S_IDLE && cmd_valid) begin
        lat_a  <= cmd_a;
        lat_b  <= cmd_b;
        lat_op <= cmd_op;
      end
      // Loaded as WR_OP hands over to EXEC; EXEC leaves when it reaches 1.
      if (state == S_WR_OP)
        exec_cnt <= EXEC_LOAD;
      else if (state == S_EXEC && exec_cnt != 4'd0)
        exec_cnt <= exec_cnt - 4'd1;
      // Result is captured from the combinational read of slot 0.
      if (state == S_RD) begin
        res_data  <= mem_rd_data;
        res_valid <= 1'b1;
      end else if (state == S_HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nx = S_WR_A;
      S_WR_A:  state_nx = S_WR_B;
      S_WR_B:  state_nx = S_WR_OP;
      S_WR_OP: state_nx = S_EXEC;
      S_EXEC:  if (exec_cnt <= 4'd1) state_nx = S_WB;
      S_WB:    state_nx = S_RD;
      S_RD:    state_nx = S_HOLD;
      S_HOLD:  if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore memory-port decode; unused address/data lines are driven to zero.
  always_comb begin
    mem_wr_enb  = 1'b0;
    mem_rd_enb  = 1'b0;
    mem_addr    = ADDR_RES;
    mem_wr_data = '0;
    case (state)
      S_WR_A: begin
        mem_wr_enb  = 1'b1;
        mem_addr    = ADDR_A;
        mem_wr_data = lat_a;
      end
      S_WR_B: begin
        mem_wr_enb  = 1'b1;
        mem_addr    = ADDR_B;
        mem_wr_data = lat_b;
      end
      S_WR_OP: begin
        mem_wr_enb  = 1'b1;
        mem_addr    = ADDR_OP;
        mem_wr_data = lat_op;
      end
      S_WB: begin
        mem_wr_enb  = 1'b1;
        mem_addr    = ADDR_RES;
        mem_wr_data = alu_result;
      end
      S_RD: begin
        mem_rd_enb  = 1'b1;
        mem_addr    = ADDR_RES;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule
